// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants and owner encoding for the 8-digit display arbiter.
package seg_display_arbiter_pkg;

  localparam int         DIGITS = 8;
  localparam logic [7:0] EMP    = 8'h00;

  // Encodings 0..2 equal the source index so they double as req bit positions.
  typedef enum logic [1:0] {
    OWN_MENU = 2'd0,
    OWN_PLAY = 2'd1,
    OWN_MSG  = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  function automatic logic [2:0] owner_onehot(input owner_t o);
    logic [2:0] g;
    g = 3'b000;
    case (o)
      OWN_MENU: g = 3'b001;
      OWN_PLAY: g = 3'b010;
      OWN_MSG:  g = 3'b100;
      default:  g = 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_scan_timer.sv
// Digit-step divider and scan index; frame_end marks the last step of digit 7.
module seg_scan_timer #(
  parameter int SCAN_DIV = 200000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] scan_idx,
  output logic       frame_end
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (scan_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= 3'd0;
    end else if (tick) begin
      div_cnt  <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates three frame sources onto the scanned 7-seg display, switching owners only at frame ends.
// Optional SEG_SWITCH_BLANK_EN: one blank frame is shown after every owner change.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int SCAN_DIV        = 200000,
  parameter int MIN_HOLD_FRAMES = 4,
  parameter int MSG_FRAMES      = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  output logic [2:0]  grant,
  output logic        msg_done,
  output logic [7:0]  seg_en,
  output logic [7:0]  tube1,
  output logic [7:0]  tube2
);

  localparam int              HOLD_W   = $clog2(MIN_HOLD_FRAMES + 1);
  localparam int              MSG_W    = $clog2(MSG_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_FRAMES);
  localparam logic [MSG_W-1:0]  MSG_LAST = MSG_W'(MSG_FRAMES - 1);
  localparam logic [63:0]     BLANK_FRAME = {DIGITS{EMP}};

  logic [2:0]  scan_idx;
  logic        frame_end;

  owner_t            owner, owner_nxt, winner;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [MSG_W-1:0]  msg_cnt, msg_nxt;
  logic              lockout, lockout_nxt;
  logic              owner_req, msg_timeout, excl_msg, do_switch, owner_chg;
  logic [63:0]       shadow, shadow_nxt, frame_sel;
  logic [7:0]        digit_p0;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .scan_idx  (scan_idx),
    .frame_end (frame_end)
  );

  always_comb begin
    owner_req = 1'b0;
    case (owner)
      OWN_MENU: owner_req = req[0];
      OWN_PLAY: owner_req = req[1];
      OWN_MSG:  owner_req = req[2];
      default:  owner_req = 1'b0;
    endcase

    // A message that runs to its limit must hand over in the same frame_end.
    msg_timeout = (owner == OWN_MSG) && req[2] && (msg_cnt == MSG_LAST);
    excl_msg    = lockout || msg_timeout;

    winner = OWN_NONE;
    if (req[2] && !excl_msg) winner = OWN_MSG;
    else if (req[1])         winner = OWN_PLAY;
    else if (req[0])         winner = OWN_MENU;

    do_switch = (owner == OWN_NONE) || !owner_req || (winner == OWN_MSG) || msg_timeout ||
                ((winner != OWN_NONE) && (winner > owner) && (hold_cnt >= HOLD_MAX));

    owner_nxt = owner;
    if (frame_end && do_switch) owner_nxt = winner;
    owner_chg = (owner_nxt != owner);

    hold_nxt = hold_cnt;
    msg_nxt  = msg_cnt;
    if (frame_end) begin
      if (owner_chg) begin
        hold_nxt = '0;
        msg_nxt  = '0;
      end else begin
        if (hold_cnt < HOLD_MAX) hold_nxt = hold_cnt + HOLD_W'(1);
        if (owner == OWN_MSG)    msg_nxt  = msg_cnt + MSG_W'(1);
      end
    end

    lockout_nxt = lockout;
    if (frame_end && msg_timeout) lockout_nxt = 1'b1;
    else if (!req[2])             lockout_nxt = 1'b0;

    frame_sel = BLANK_FRAME;
    case (owner_nxt)
      OWN_MENU: frame_sel = frame0;
      OWN_PLAY: frame_sel = frame1;
      OWN_MSG:  frame_sel = frame2;
      default:  frame_sel = BLANK_FRAME;
    endcase

    shadow_nxt = shadow;
    if (frame_end) begin
`ifdef SEG_SWITCH_BLANK_EN
      shadow_nxt = owner_chg ? BLANK_FRAME : frame_sel;
`else
      shadow_nxt = frame_sel;
`endif
    end

    digit_p0 = shadow[{scan_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= OWN_NONE;
      hold_cnt <= '0;
      msg_cnt  <= '0;
      lockout  <= 1'b0;
      shadow   <= BLANK_FRAME;
    end else begin
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      msg_cnt  <= msg_nxt;
      lockout  <= lockout_nxt;
      shadow   <= shadow_nxt;
    end
  end

  // Output stage: registered pins, one cycle behind scan_idx/shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= 3'b000;
      msg_done <= 1'b0;
      seg_en   <= 8'h01;
      tube1    <= EMP;
      tube2    <= EMP;
    end else begin
      grant    <= owner_onehot(owner_nxt);
      msg_done <= frame_end && msg_timeout;
      seg_en   <= 8'h01 << scan_idx;
      tube1    <= scan_idx[2] ? EMP : digit_p0;
      tube2    <= scan_idx[2] ? digit_p0 : EMP;
    end
  end

endmodule
